ascon_receiver: RTL and testbench
=================================

# ascon_receiver

Iterative ASCON-128 authenticated-decryption core for the receive side of the link. It takes the key, nonce, IV, three associated-data blocks and two received ciphertext blocks, and runs the ASCON permutation one round per clock. It returns the two recovered plaintext blocks and the full 320-bit final state; the tag lives in state words y3/y4. It sits between the link deframer, which supplies the blocks, and the consumer, which reads the plaintext and checks the tag.

## Interface
Parameters: none.

Reset and clock are already decided for this block: one clock; reset is synchronous and active-high.

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; all data inputs are sampled on the same edge
- iv  in  64  ASCON-128 IV; nominal value 80400C0600000000
- k0, k1  in  64 each  key, high word / low word
- n0, n1  in  64 each  nonce, high word / low word
- d0, d1, d2  in  64 each  associated-data blocks, already padded by the sender
- pln0, pln1  in  64 each  received ciphertext blocks, both full-length
- y0..y4  out  64 each  state words after finalization; tag = {y3, y4}
- out0, out1  out  64 each  recovered plaintext blocks
- busy  out  1  high while a decryption is running
- done  out  1  one-cycle pulse when all outputs are valid

## Operation
- Round function, applied in this order:
  - constant: x2 ^= c
  - 5-bit ASCON S-box across the 64 bit-slices
  - linear layer: x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41); each word is XORed with its two right-rotations
- Round constant for round index i: c = ((0xF−i)<<4)|i.
  - p12 uses i = 0..11
  - p6 uses i = 6..11
- FSM: IDLE → INIT → AD → CT → FIN → IDLE.
- IDLE, on start:
  - latch all inputs
  - load state {iv, k0, k1, n0, n1}
  - assert busy
- INIT: 12 rounds. Then x3 ^= k0, x4 ^= k1.
- AD: for each block j = 0..2:
  - x0 ^= d_j
  - 6 rounds
- After the AD blocks: x4 ^= 1 (domain separation).
- CT, for each block j = 0..1:
  - out_j = x0 ^ pln_j
  - then x0 = pln_j
  - 6 rounds
- After the CT blocks: x0 ^= 0x8000000000000000 (padding block for a full-length message).
- FIN:
  - x1 ^= k0, x2 ^= k1
  - 12 rounds
  - x3 ^= k0, x4 ^= k1
  - drive y0..y4
  - pulse done
  - return to IDLE
- Phase-boundary XORs are applied combinationally to the state feeding the first round of the next phase. They never take a cycle of their own.
- All 64-bit arithmetic is XOR, AND, NOT and rotate only; no carries.

## Timing
- Total 54 round cycles: 12 INIT + 18 AD + 12 CT + 12 FIN.
- start sampled at edge 0. Round r completes at edge r (r = 1..54). done is high for exactly the cycle following edge 54; busy drops in that same cycle.
- out0 registers at the edge that completes round 30. out1 registers at the edge that completes round 36.
- y0..y4 register at edge 54 and hold until the next start or reset.
- start while busy is ignored. A new start is accepted in the done cycle.
- Reset:
  - all outputs, busy, done and the state register go to 0; FSM goes to IDLE
  - reset mid-operation aborts the run with no done pulse
  - rst has priority over start on the same edge
- Inputs may change after the start edge without effect.

## Configuration
- ASCON_TAG_CHECK_EN defined:
  - adds inputs tag0 and tag1 (64 bits each), latched on start
  - adds output tag_ok (1 bit), valid with done and held afterwards
  - tag_ok = ({y3, y4} == {tag0, tag1})
  - when tag_ok is 0, out0 and out1 are forced to 0
  - tag_ok resets to 0
- Undefined: none of these ports exist; plaintext is always released.

## Test plan
- Reset: rst high for 2 cycles with arbitrary inputs → all outputs, busy and done are 0.
- Nominal vector:
  - stimulus: iv=80400C0600000000, k=265F1C12888E151A_C74F26B30A8C44B2, n=369C801F3AE8D0EA_9BF367D58FD211FF, d=0000000000787878/0000000000878787/0000000000009090, pln=55C7C8E752D9390E/9E54495E0A21074C
  - response: done exactly 55 cycles after start is sampled; out0/out1/y0..y4 bit-exact against the team's ASCON-128 C golden model
- Linearity check: rerun the nominal vector with pln0 ^= 1 → out0 differs from the nominal run only in bit 0; out1 and y0..y4 change.
- Busy protection: pulse start again at cycle 10 with different data → outputs equal the nominal vector's; exactly one done pulse.
- Abort: assert rst at cycle 20 of a run, then start the nominal vector → no done at cycle 55 of the aborted run; the second run matches the nominal results.
- ASCON_TAG_CHECK_EN:
  - tag = nominal {y3, y4} → tag_ok=1, plaintext released
  - tag with bit 0 flipped → tag_ok=0, out0=out1=0

Source files
------------

// File: rtl/ascon_receiver_if.sv
// ascon_receiver_if: bundle between the link deframer / plaintext consumer
// (master side) and the ascon_receiver core (slave side).
//
// Handshake: start is a single-cycle request. All data inputs are sampled on
// the edge where start is seen while the core is idle. A start that arrives
// while busy is ignored. done pulses for one cycle once out0/out1/y0..y4 are
// valid. The outputs then hold until they are overwritten or reset.
//
// Signals:
//   start                   request, sampled with all data inputs
//   iv, k0, k1, n0, n1      IV, key and nonce words
//   d0, d1, d2              padded associated-data blocks
//   pln0, pln1              received ciphertext blocks
//   y0..y4                  final state; tag = {y3, y4}
//   out0, out1              recovered plaintext
//   busy, done              status
// With ASCON_TAG_CHECK_EN defined, the bundle also carries:
//   tag0, tag1              expected tag
//   tag_ok                  tag comparison result
interface ascon_receiver_if;
  logic        start;
  logic [63:0] iv, k0, k1, n0, n1;
  logic [63:0] d0, d1, d2;
  logic [63:0] pln0, pln1;
  logic [63:0] y0, y1, y2, y3, y4;
  logic [63:0] out0, out1;
  logic        busy, done;
`ifdef ASCON_TAG_CHECK_EN
  logic [63:0] tag0, tag1;
  logic        tag_ok;

  modport master (
    output start, iv, k0, k1, n0, n1, d0, d1, d2, pln0, pln1, tag0, tag1,
    input  y0, y1, y2, y3, y4, out0, out1, busy, done, tag_ok
  );
  modport slave (
    input  start, iv, k0, k1, n0, n1, d0, d1, d2, pln0, pln1, tag0, tag1,
    output y0, y1, y2, y3, y4, out0, out1, busy, done, tag_ok
  );
`else
  modport master (
    output start, iv, k0, k1, n0, n1, d0, d1, d2, pln0, pln1,
    input  y0, y1, y2, y3, y4, out0, out1, busy, done
  );
  modport slave (
    input  start, iv, k0, k1, n0, n1, d0, d1, d2, pln0, pln1,
    output y0, y1, y2, y3, y4, out0, out1, busy, done
  );
`endif
endinterface

// File: rtl/ascon_receiver.sv
// ascon_receiver: iterative ASCON-128 decryption core, one permutation round
// per clock. It processes three AD blocks and two full ciphertext blocks,
// and returns the plaintext and the finalized 320-bit state (tag = {y3, y4}).
// A run takes 54 round cycles; done pulses in the cycle after the last one.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        ascon_receiver_if.slave (start/data in, results/status out)
//   dbg_state  current FSM state (0 IDLE, 1 INIT, 2 AD, 3 CT, 4 FIN)
//
// Optional feature macro: ASCON_TAG_CHECK_EN. When it is defined, the core
// compares {y3, y4} against the latched {tag0, tag1}, reports the result on
// tag_ok, and withholds the plaintext (out0/out1 read 0) unless the tag
// matches.
module ascon_receiver (
  input  logic               clk,
  input  logic               rst,
  ascon_receiver_if.slave    bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_INIT = 3'd1, S_AD = 3'd2, S_CT = 3'd3, S_FIN = 3'd4
  } state_t;

  typedef logic [4:0][63:0] st_t;  // index 0 is x0

  function automatic logic [63:0] ror(input logic [63:0] w, input int unsigned n);
    return (w >> n) | (w << (64 - n));
  endfunction

  // One full round: constant addition, bit-sliced S-box, linear layer.
  function automatic st_t ascon_round(input st_t s, input logic [3:0] ri);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    logic [3:0]  hi;
    st_t         r;
    hi = 4'hF - ri;
    a0 = s[0]; a1 = s[1]; a2 = s[2] ^ {56'd0, hi, ri}; a3 = s[3]; a4 = s[4];
    a0 = a0 ^ a4; a4 = a4 ^ a3; a2 = a2 ^ a1;
    t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
    a0 = a0 ^ t1; a1 = a1 ^ t2; a2 = a2 ^ t3; a3 = a3 ^ t4; a4 = a4 ^ t0;
    a1 = a1 ^ a0; a0 = a0 ^ a4; a3 = a3 ^ a2; a2 = ~a2;
    r[0] = a0 ^ ror(a0, 19) ^ ror(a0, 28);
    r[1] = a1 ^ ror(a1, 61) ^ ror(a1, 39);
    r[2] = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
    r[3] = a3 ^ ror(a3, 10) ^ ror(a3, 17);
    r[4] = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
    return r;
  endfunction

  state_t      state, state_nxt;
  st_t         x, x_pre, x_rnd;
  logic [3:0]  ri;          // ASCON round index of the round running now
  logic [1:0]  blk;         // block number within AD / CT
  logic [3:0]  ri_load;
  logic        last_round, cap_out0, cap_out1, finish;
  logic [63:0] k0_q, k1_q, d0_q, d1_q, d2_q, pln0_q, pln1_q;
  logic [63:0] d_sel, pln_sel;
  logic [63:0] out0_q, out1_q, y0_q, y1_q, y2_q, y3_q, y4_q;
  logic        done_q;
`ifdef ASCON_TAG_CHECK_EN
  logic [63:0] tag0_q, tag1_q;
  logic        tag_ok_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Each run phase ends on round index 11 of its last block.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_INIT;
      S_INIT: if (ri == 4'd11) state_nxt = S_AD;
      S_AD:   if (ri == 4'd11 && blk == 2'd2) state_nxt = S_CT;
      S_CT:   if (ri == 4'd11 && blk == 2'd1) state_nxt = S_FIN;
      S_FIN:  if (ri == 4'd11) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath control. Phase-boundary XORs are folded into the state
  // that feeds the first round of each block, so they cost no extra cycle.
  always_comb begin
    x_pre   = x;
    d_sel   = (blk == 2'd0) ? d0_q : ((blk == 2'd1) ? d1_q : d2_q);
    pln_sel = (blk == 2'd0) ? pln0_q : pln1_q;
    case (state)
      S_AD: if (ri == 4'd6) begin
        if (blk == 2'd0) begin
          x_pre[3] = x_pre[3] ^ k0_q;
          x_pre[4] = x_pre[4] ^ k1_q;
        end
        x_pre[0] = x_pre[0] ^ d_sel;
      end
      S_CT: if (ri == 4'd6) begin
        if (blk == 2'd0) x_pre[4] = x_pre[4] ^ 64'd1;  // domain separation
        x_pre[0] = pln_sel;
      end
      S_FIN: if (ri == 4'd0) begin
        x_pre[0] = x_pre[0] ^ 64'h8000_0000_0000_0000;  // padding block
        x_pre[1] = x_pre[1] ^ k0_q;
        x_pre[2] = x_pre[2] ^ k1_q;
      end
      default: ;
    endcase
    x_rnd      = ascon_round(x_pre, ri);
    last_round = (ri == 4'd11);
    // Plaintext j is the rate word after the last round preceding CT block j.
    cap_out0   = (state == S_AD) && last_round && (blk == 2'd2);
    cap_out1   = (state == S_CT) && last_round && (blk == 2'd0);
    finish     = (state == S_FIN) && last_round;
    ri_load    = (state_nxt == S_AD || state_nxt == S_CT) ? 4'd6 : 4'd0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0; ri <= '0; blk <= '0;
      k0_q <= '0; k1_q <= '0; d0_q <= '0; d1_q <= '0; d2_q <= '0;
      pln0_q <= '0; pln1_q <= '0;
      out0_q <= '0; out1_q <= '0;
      y0_q <= '0; y1_q <= '0; y2_q <= '0; y3_q <= '0; y4_q <= '0;
      done_q <= 1'b0;
`ifdef ASCON_TAG_CHECK_EN
      tag0_q <= '0; tag1_q <= '0; tag_ok_q <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      done_q <= 1'b0;
      if (bus.start) begin
        x      <= {bus.n1, bus.n0, bus.k1, bus.k0, bus.iv};
        ri     <= '0;
        blk    <= '0;
        k0_q   <= bus.k0;   k1_q   <= bus.k1;
        d0_q   <= bus.d0;   d1_q   <= bus.d1;   d2_q <= bus.d2;
        pln0_q <= bus.pln0; pln1_q <= bus.pln1;
`ifdef ASCON_TAG_CHECK_EN
        tag0_q   <= bus.tag0;
        tag1_q   <= bus.tag1;
        tag_ok_q <= 1'b0;
`endif
      end
    end else begin
      x <= x_rnd;
      if (last_round) begin
        ri  <= ri_load;
        blk <= (state_nxt != state) ? 2'd0 : blk + 2'd1;
      end else begin
        ri <= ri + 4'd1;
      end
      if (cap_out0) out0_q <= x_rnd[0] ^ pln0_q;
      if (cap_out1) out1_q <= x_rnd[0] ^ pln1_q;
      done_q <= finish;
      if (finish) begin
        y0_q <= x_rnd[0];
        y1_q <= x_rnd[1];
        y2_q <= x_rnd[2];
        y3_q <= x_rnd[3] ^ k0_q;
        y4_q <= x_rnd[4] ^ k1_q;
`ifdef ASCON_TAG_CHECK_EN
        tag_ok_q <= ({x_rnd[3] ^ k0_q, x_rnd[4] ^ k1_q} == {tag0_q, tag1_q});
`endif
      end
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_q;
  assign bus.y0    = y0_q;
  assign bus.y1    = y1_q;
  assign bus.y2    = y2_q;
  assign bus.y3    = y3_q;
  assign bus.y4    = y4_q;
  assign dbg_state = state;
`ifdef ASCON_TAG_CHECK_EN
  assign bus.tag_ok = tag_ok_q;
  assign bus.out0   = tag_ok_q ? out0_q : '0;
  assign bus.out1   = tag_ok_q ? out1_q : '0;
`else
  assign bus.out0   = out0_q;
  assign bus.out1   = out1_q;
`endif

endmodule

// File: tb/tb_ascon_receiver.sv
// tb_ascon_receiver: self-checking bench for ascon_receiver. A behavioural
// ASCON model (table S-box, generic round loop) produces expected results for
// nominal, bit-flipped, random, busy-restart and abort scenarios.
// Build with ASCON_TAG_CHECK_EN defined to exercise the tag-check variant.
module tb_ascon_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  ascon_receiver_if bus ();

  ascon_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] iv, k0, k1, n0, n1, d0, d1, d2, c0, c1;
  } vec_t;
  typedef struct packed {
    logic [63:0] out0, out1, y0, y1, y2, y3, y4;
  } res_t;
  typedef logic [4:0][63:0] st_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] sbox5(input logic [4:0] v);
    case (v)
      5'h00: return 5'h04; 5'h01: return 5'h0b; 5'h02: return 5'h1f; 5'h03: return 5'h14;
      5'h04: return 5'h1a; 5'h05: return 5'h15; 5'h06: return 5'h09; 5'h07: return 5'h02;
      5'h08: return 5'h1b; 5'h09: return 5'h05; 5'h0a: return 5'h08; 5'h0b: return 5'h12;
      5'h0c: return 5'h1d; 5'h0d: return 5'h03; 5'h0e: return 5'h06; 5'h0f: return 5'h1c;
      5'h10: return 5'h1e; 5'h11: return 5'h13; 5'h12: return 5'h07; 5'h13: return 5'h0e;
      5'h14: return 5'h00; 5'h15: return 5'h0d; 5'h16: return 5'h11; 5'h17: return 5'h18;
      5'h18: return 5'h10; 5'h19: return 5'h0c; 5'h1a: return 5'h01; 5'h1b: return 5'h19;
      5'h1c: return 5'h16; 5'h1d: return 5'h0a; 5'h1e: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  // Last nr rounds of the 12-round schedule.
  function automatic st_t perm(input st_t s_in, input int nr);
    st_t        s, t;
    logic [4:0] v;
    int         ra[5], rb[5];
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    s  = s_in;
    for (int i = 12 - nr; i < 12; i++) begin
      s[2] = s[2] ^ 64'((15 - i) * 16 + i);
      for (int b = 0; b < 64; b++) begin
        v = sbox5({s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]});
        for (int w = 0; w < 5; w++) t[w][b] = v[4 - w];
      end
      for (int w = 0; w < 5; w++) s[w] = t[w] ^ rotr(t[w], ra[w]) ^ rotr(t[w], rb[w]);
    end
    return s;
  endfunction

  function automatic res_t ascon_model(input vec_t v);
    st_t         s;
    res_t        r;
    logic [63:0] ad[3], ct[2], pt[2];
    ad[0] = v.d0; ad[1] = v.d1; ad[2] = v.d2;
    ct[0] = v.c0; ct[1] = v.c1;
    s[0] = v.iv; s[1] = v.k0; s[2] = v.k1; s[3] = v.n0; s[4] = v.n1;
    s = perm(s, 12);
    s[3] = s[3] ^ v.k0; s[4] = s[4] ^ v.k1;
    for (int j = 0; j < 3; j++) begin
      s[0] = s[0] ^ ad[j];
      s = perm(s, 6);
    end
    s[4] = s[4] ^ 64'd1;
    for (int j = 0; j < 2; j++) begin
      pt[j] = s[0] ^ ct[j];
      s[0]  = ct[j];
      s = perm(s, 6);
    end
    s[0] = s[0] ^ 64'h8000_0000_0000_0000;
    s[1] = s[1] ^ v.k0; s[2] = s[2] ^ v.k1;
    s = perm(s, 12);
    s[3] = s[3] ^ v.k0; s[4] = s[4] ^ v.k1;
    r.out0 = pt[0]; r.out1 = pt[1];
    r.y0 = s[0]; r.y1 = s[1]; r.y2 = s[2]; r.y3 = s[3]; r.y4 = s[4];
    return r;
  endfunction

  // ---------------- drivers ----------------
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.iv = rnd64(); v.k0 = rnd64(); v.k1 = rnd64(); v.n0 = rnd64(); v.n1 = rnd64();
    v.d0 = rnd64(); v.d1 = rnd64(); v.d2 = rnd64(); v.c0 = rnd64(); v.c1 = rnd64();
    return v;
  endfunction

  task automatic drive_vec(input vec_t v, input logic [63:0] t0, input logic [63:0] t1);
    bus.iv = v.iv; bus.k0 = v.k0; bus.k1 = v.k1; bus.n0 = v.n0; bus.n1 = v.n1;
    bus.d0 = v.d0; bus.d1 = v.d1; bus.d2 = v.d2; bus.pln0 = v.c0; bus.pln1 = v.c1;
`ifdef ASCON_TAG_CHECK_EN
    bus.tag0 = t0; bus.tag1 = t1;
`else
    if (t0 === 64'hx && t1 === 64'hx) bus.start = 1'b0;
`endif
  endtask

  task automatic score(input string tag, input res_t got, input res_t exp);
    logic [63:0] g[7];
    g = '{got.out0, got.out1, got.y0, got.y1, got.y2, got.y3, got.y4};
    exp_q.push_back(exp.out0); exp_q.push_back(exp.out1);
    exp_q.push_back(exp.y0); exp_q.push_back(exp.y1); exp_q.push_back(exp.y2);
    exp_q.push_back(exp.y3); exp_q.push_back(exp.y4);
    for (int i = 0; i < 7; i++) check($sformatf("%s_w%0d", tag, i), g[i], exp_q.pop_front());
  endtask

  // One decryption. restart_at >= 0 pulses a second start with random data
  // that many cycles into the run. flip_tag corrupts bit 0 of the tag.
  task automatic run(input string tag, input vec_t v, input int restart_at,
                     input logic flip_tag, output res_t got);
    res_t m;
    int   e;
    m = ascon_model(v);
    @(negedge clk);
    drive_vec(v, m.y3, m.y4 ^ {63'd0, flip_tag});
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drive_vec(rand_vec(), rnd64(), rnd64());  // late input changes must not matter
    check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    e = 0;
    while (!bus.done && e < 200) begin
      @(negedge clk);
      e++;
      if (e == restart_at) begin
        drive_vec(rand_vec(), rnd64(), rnd64());
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
`ifndef ASCON_TAG_CHECK_EN
      if (e == 30) check({tag, "_out0_edge30"}, bus.out0, m.out0);
      if (e == 36) check({tag, "_out1_edge36"}, bus.out1, m.out1);
`endif
    end
    bus.start = 1'b0;
    check({tag, "_done_latency"}, 64'(e), 64'd54);
    check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    got = '{bus.out0, bus.out1, bus.y0, bus.y1, bus.y2, bus.y3, bus.y4};
    if (!flip_tag) score(tag, got, m);
    @(negedge clk);
    check({tag, "_done_single"}, 64'(bus.done), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t nom, lin;
    res_t got, nom_got, m;
    int   dn;

    nom.iv = 64'h80400C0600000000;
    nom.k0 = 64'h265F1C12888E151A; nom.k1 = 64'hC74F26B30A8C44B2;
    nom.n0 = 64'h369C801F3AE8D0EA; nom.n1 = 64'h9BF367D58FD211FF;
    nom.d0 = 64'h0000000000787878; nom.d1 = 64'h0000000000878787;
    nom.d2 = 64'h0000000000009090;
    nom.c0 = 64'h55C7C8E752D9390E; nom.c1 = 64'h9E54495E0A21074C;

    // Reset with arbitrary inputs and start held high
    rst = 1'b1;
    bus.start = 1'b1;
    drive_vec(rand_vec(), rnd64(), rnd64());
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_out0", bus.out0, 64'd0);
    check("rst_out1", bus.out1, 64'd0);
    check("rst_y0", bus.y0, 64'd0);
    check("rst_y3", bus.y3, 64'd0);
    check("rst_y4", bus.y4, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
`ifdef ASCON_TAG_CHECK_EN
    check("rst_tag_ok", 64'(bus.tag_ok), 64'd0);
`endif
    rst = 1'b0;
    bus.start = 1'b0;

    // Nominal vector
    run("nom", nom, -1, 1'b0, nom_got);
`ifdef ASCON_TAG_CHECK_EN
    check("nom_tag_ok", 64'(bus.tag_ok), 64'd1);
`endif

    // Linearity: flipping ciphertext bit 0 flips only plaintext bit 0
    lin = nom;
    lin.c0 = lin.c0 ^ 64'd1;
    run("lin", lin, -1, 1'b0, got);
    check("lin_out0_delta", got.out0 ^ nom_got.out0, 64'd1);
    check("lin_out1_changed", 64'(got.out1 != nom_got.out1), 64'd1);
    check("lin_y_changed",
          64'({got.y0, got.y1, got.y2, got.y3, got.y4} !=
              {nom_got.y0, nom_got.y1, nom_got.y2, nom_got.y3, nom_got.y4}), 64'd1);

    // Random vectors
    for (int i = 0; i < 4; i++) run($sformatf("rnd%0d", i), rand_vec(), -1, 1'b0, got);

    // Start while busy is ignored; exactly one done pulse
    run("busy", nom, 10, 1'b0, got);
    dn = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("busy_extra_done", 64'(dn), 64'd0);

    // Abort mid-run with reset, then rerun the nominal vector
    @(negedge clk);
    drive_vec(nom, 64'd0, 64'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    check("abort_y4", bus.y4, 64'd0);
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);
    run("after_abort", nom, -1, 1'b0, got);

`ifdef ASCON_TAG_CHECK_EN
    // Corrupted tag: plaintext withheld, state still reported
    m = ascon_model(nom);
    run("badtag", nom, -1, 1'b1, got);
    check("badtag_tag_ok", 64'(bus.tag_ok), 64'd0);
    check("badtag_out0", got.out0, 64'd0);
    check("badtag_out1", got.out1, 64'd0);
    check("badtag_y3", got.y3, m.y3);
    check("badtag_y4", got.y4, m.y4);
`else
    m = ascon_model(nom);
    check("nom_final_y3", bus.y3, m.y3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
